// File: rtl/reset_sequencer_pkg.sv
// Shared types and default constants for the reset sequencer slice.
`timescale 1ns/1ps
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      HOLD  = 2'd1,
      STAGE = 2'd2,
      RUN   = 2'd3
   } reset_state_t;

   localparam int unsigned RST_SYNC_STAGES = 2;
   localparam int unsigned RST_HOLD_CYCLES = 16;
   localparam int unsigned RST_STAGE_GAP   = 4;
   localparam int unsigned RST_NUM_OUTS    = 3;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Staged-reset bundle: soft request in, staged resets/status out.
`timescale 1ns/1ps
interface reset_sequencer_if
   import reset_sequencer_pkg::*;
#(
   parameter int unsigned NUM_OUTS = RST_NUM_OUTS
);

   logic                soft_req_i;
   logic [NUM_OUTS-1:0] rst_no;
   logic                ready_o;
   reset_state_t        state_o;

   // Consumer side: requests soft reset, observes the staged resets.
   modport master (
      output soft_req_i,
      input  rst_no,
      input  ready_o,
      input  state_o
   );

   // Sequencer side.
   modport slave (
      input  soft_req_i,
      output rst_no,
      output ready_o,
      output state_o
   );

endinterface

// File: rtl/reset_sequencer_sync_bit.sv
// Generic N-flop bit synchronizer with async clear to 0.
`timescale 1ns/1ps
module sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   if (STAGES < 2) begin : g_bad_stages
      $error("sync_bit: STAGES must be >= 2");
   end

   logic [STAGES-1:0] sync_q;

   // Shift chain; asynchronously cleared, synchronously filled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: async assert, synchronised, stretched and staggered release.
`timescale 1ns/1ps
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = RST_SYNC_STAGES,
   parameter int unsigned HOLD_CYCLES = RST_HOLD_CYCLES,
   parameter int unsigned STAGE_GAP   = RST_STAGE_GAP,
   parameter int unsigned NUM_OUTS    = RST_NUM_OUTS
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   reset_sequencer_if.slave  bus
);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("reset_sequencer: SYNC_STAGES must be >= 2");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("reset_sequencer: HOLD_CYCLES must be >= 1");
   end
   if (STAGE_GAP < 1) begin : g_bad_gap
      $error("reset_sequencer: STAGE_GAP must be >= 1");
   end
   if (NUM_OUTS < 1) begin : g_bad_outs
      $error("reset_sequencer: NUM_OUTS must be >= 1");
   end

   localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, STAGE_GAP) + 1);
   localparam int unsigned IDX_W = $clog2(NUM_OUTS + 1);

   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_GAP - 1);
   localparam logic [IDX_W-1:0] IDX_FIRST  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_OUTS - 1);

   reset_state_t        state_q, state_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;
   logic [IDX_W-1:0]    idx_q,   idx_d;
   logic [NUM_OUTS-1:0] rst_q,   rst_d;
   logic                ready_q, ready_d;
   logic                sync_done;

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (1'b1),
      .q_o    (sync_done)
   );

   // State and output registers; rst_ni low clears everything at once.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= SYNC;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_q   <= rst_d;
         ready_q <= ready_d;
      end
   end

   // Next-state logic: release bits one at a time, soft request restarts HOLD.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      rst_d   = rst_q;
      ready_d = ready_q;

      if (state_q != SYNC && bus.soft_req_i) begin
         state_d = HOLD;
         cnt_d   = '0;
         idx_d   = '0;
         rst_d   = '0;
         ready_d = 1'b0;
      end else begin
         unique case (state_q)
            SYNC: begin
               if (sync_done) begin
                  state_d = HOLD;
                  cnt_d   = '0;
               end
            end
            HOLD: begin
               if (cnt_q == HOLD_LAST) begin
                  rst_d[0] = 1'b1;
                  cnt_d    = '0;
                  if (NUM_OUTS == 1) begin
                     state_d = RUN;
                     idx_d   = '0;
                     ready_d = 1'b1;
                  end else begin
                     state_d = STAGE;
                     idx_d   = IDX_FIRST;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            STAGE: begin
               if (cnt_q == STAGE_LAST) begin
                  // Index decode by loop keeps the select width-clean for any NUM_OUTS.
                  for (int unsigned k = 0; k < NUM_OUTS; k++) begin
                     if (idx_q == IDX_W'(k)) begin
                        rst_d[k] = 1'b1;
                     end
                  end
                  cnt_d = '0;
                  if (idx_q == IDX_LAST) begin
                     state_d = RUN;
                     idx_d   = '0;
                     ready_d = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            RUN: begin
               state_d = RUN;
            end
            default: begin
               state_d = SYNC;
               cnt_d   = '0;
               idx_d   = '0;
               rst_d   = '0;
               ready_d = 1'b0;
            end
         endcase
      end
   end

   assign bus.rst_no  = rst_q;
   assign bus.ready_o = ready_q;
   assign bus.state_o = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed self-checking bench for reset_sequencer (default and single-output configs).
`timescale 1ns/1ps
module tb_reset_sequencer;
   import reset_sequencer_pkg::*;

   logic clk;
   logic rst_n;
   logic rst2_n;

   int unsigned n_pass;
   int unsigned n_total;

   reset_sequencer_if #(.NUM_OUTS(3)) bus_a ();
   reset_sequencer_if #(.NUM_OUTS(1)) bus_b ();

   reset_sequencer #(
      .SYNC_STAGES (2),
      .HOLD_CYCLES (16),
      .STAGE_GAP   (4),
      .NUM_OUTS    (3)
   ) dut_a (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_a)
   );

   reset_sequencer #(
      .SYNC_STAGES (2),
      .HOLD_CYCLES (1),
      .STAGE_GAP   (4),
      .NUM_OUTS    (1)
   ) dut_b (
      .clk_i  (clk),
      .rst_ni (rst2_n),
      .bus    (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Assert reset, then release between edges so the next posedge is edge 1.
   task automatic do_release();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      rst2_n = 1'b0;
      bus_a.soft_req_i = 1'b0;
      bus_b.soft_req_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (bus_a.rst_no !== 3'b000) $display("FAIL reset_rst_no got=%b exp=000", bus_a.rst_no);
      else n_pass++;
      n_total++;
      if (bus_a.ready_o !== 1'b0) $display("FAIL reset_ready got=%b exp=0", bus_a.ready_o);
      else n_pass++;
      n_total++;
      if (bus_a.state_o !== SYNC) $display("FAIL reset_state got=%0d exp=%0d", bus_a.state_o, SYNC);
      else n_pass++;
      n_total++;
      if (bus_b.rst_no !== 1'b0 || bus_b.ready_o !== 1'b0)
         $display("FAIL reset_b got rst=%b ready=%b exp rst=0 ready=0", bus_b.rst_no, bus_b.ready_o);
      else n_pass++;
   endtask

   // Edges 1..30 after a release: 001@19, 011@23, 111@27, ready/RUN@27.
   task automatic check_default_sequence(input string tag);
      logic [2:0]   exp_rst;
      logic         exp_rdy;
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk);
         #1;
         exp_rst = (e >= 27) ? 3'b111 : (e >= 23) ? 3'b011 : (e >= 19) ? 3'b001 : 3'b000;
         exp_rdy = (e >= 27);
         n_total++;
         if (bus_a.rst_no !== exp_rst || bus_a.ready_o !== exp_rdy)
            $display("FAIL %s_edge%0d got rst=%b ready=%b exp rst=%b ready=%b",
                     tag, e, bus_a.rst_no, bus_a.ready_o, exp_rst, exp_rdy);
         else n_pass++;
         if (e == 2 || e == 3 || e == 19 || e == 27) begin
            n_total++;
            if (bus_a.state_o !== ((e == 2) ? SYNC : (e == 3) ? HOLD : (e == 19) ? STAGE : RUN))
               $display("FAIL %s_state_edge%0d got=%0d", tag, e, bus_a.state_o);
            else n_pass++;
         end
      end
   endtask

   task automatic test_default_sequence();
      do_release();
      check_default_sequence("seq");
   endtask

   task automatic test_async_glitch();
      do_release();
      repeat (21) @(posedge clk);
      #1;
      n_total++;
      if (bus_a.rst_no !== 3'b001 || bus_a.state_o !== STAGE)
         $display("FAIL glitch_pre got rst=%b state=%0d exp rst=001 state=%0d", bus_a.rst_no, bus_a.state_o, STAGE);
      else n_pass++;
      #1;
      rst_n = 1'b0;
      #0.5;
      n_total++;
      if (bus_a.rst_no !== 3'b000 || bus_a.ready_o !== 1'b0 || bus_a.state_o !== SYNC)
         $display("FAIL glitch_async got rst=%b ready=%b state=%0d exp rst=000 ready=0 state=%0d",
                  bus_a.rst_no, bus_a.ready_o, bus_a.state_o, SYNC);
      else n_pass++;
      #0.5;
      rst_n = 1'b1;
      check_default_sequence("glitch");
   endtask

   task automatic test_soft_in_run();
      @(negedge clk);
      bus_a.soft_req_i = 1'b1;
      @(posedge clk);
      #1;
      n_total++;
      if (bus_a.rst_no !== 3'b000 || bus_a.ready_o !== 1'b0 || bus_a.state_o !== HOLD)
         $display("FAIL soft_run_F got rst=%b ready=%b state=%0d exp rst=000 ready=0 state=%0d",
                  bus_a.rst_no, bus_a.ready_o, bus_a.state_o, HOLD);
      else n_pass++;
      @(negedge clk);
      bus_a.soft_req_i = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         @(posedge clk);
         #1;
         if (k == 15 || k == 16 || k == 19 || k == 20 || k == 23 || k == 24) begin
            n_total++;
            if (bus_a.rst_no !== ((k >= 24) ? 3'b111 : (k >= 20) ? 3'b011 : (k >= 16) ? 3'b001 : 3'b000) ||
                bus_a.ready_o !== (k >= 24))
               $display("FAIL soft_run_F+%0d got rst=%b ready=%b", k, bus_a.rst_no, bus_a.ready_o);
            else n_pass++;
         end
      end
   endtask

   task automatic test_soft_level();
      @(negedge clk);
      bus_a.soft_req_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         n_total++;
         if (bus_a.rst_no !== 3'b000 || bus_a.state_o !== HOLD)
            $display("FAIL soft_level_hold%0d got rst=%b state=%0d exp rst=000 state=%0d",
                     k, bus_a.rst_no, bus_a.state_o, HOLD);
         else n_pass++;
      end
      @(negedge clk);
      bus_a.soft_req_i = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      n_total++;
      if (bus_a.rst_no !== 3'b000) $display("FAIL soft_level_+15 got=%b exp=000", bus_a.rst_no);
      else n_pass++;
      @(posedge clk);
      #1;
      n_total++;
      if (bus_a.rst_no !== 3'b001) $display("FAIL soft_level_+16 got=%b exp=001", bus_a.rst_no);
      else n_pass++;
   endtask

   task automatic test_soft_in_stage();
      do_release();
      repeat (20) @(posedge clk);
      #1;
      n_total++;
      if (bus_a.rst_no !== 3'b001 || bus_a.state_o !== STAGE)
         $display("FAIL soft_stage_e20 got rst=%b state=%0d exp rst=001 state=%0d", bus_a.rst_no, bus_a.state_o, STAGE);
      else n_pass++;
      @(negedge clk);
      bus_a.soft_req_i = 1'b1;
      @(posedge clk);
      #1;
      n_total++;
      if (bus_a.rst_no !== 3'b000 || bus_a.state_o !== HOLD)
         $display("FAIL soft_stage_e21 got rst=%b state=%0d exp rst=000 state=%0d", bus_a.rst_no, bus_a.state_o, HOLD);
      else n_pass++;
      @(negedge clk);
      bus_a.soft_req_i = 1'b0;
      repeat (23) @(posedge clk);
      #1;
      n_total++;
      if (bus_a.rst_no !== 3'b011 || bus_a.ready_o !== 1'b0)
         $display("FAIL soft_stage_e44 got rst=%b ready=%b exp rst=011 ready=0", bus_a.rst_no, bus_a.ready_o);
      else n_pass++;
      @(posedge clk);
      #1;
      n_total++;
      if (bus_a.rst_no !== 3'b111 || bus_a.ready_o !== 1'b1 || bus_a.state_o !== RUN)
         $display("FAIL soft_stage_e45 got rst=%b ready=%b state=%0d exp rst=111 ready=1 state=%0d",
                  bus_a.rst_no, bus_a.ready_o, bus_a.state_o, RUN);
      else n_pass++;
   endtask

   task automatic test_soft_in_sync();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus_a.soft_req_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_total++;
      if (bus_a.state_o !== SYNC) $display("FAIL soft_sync_e2 got=%0d exp=%0d", bus_a.state_o, SYNC);
      else n_pass++;
      @(posedge clk);
      @(negedge clk);
      bus_a.soft_req_i = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      n_total++;
      if (bus_a.rst_no !== 3'b000) $display("FAIL soft_sync_e18 got=%b exp=000", bus_a.rst_no);
      else n_pass++;
      @(posedge clk);
      #1;
      n_total++;
      if (bus_a.rst_no !== 3'b001) $display("FAIL soft_sync_e19 got=%b exp=001", bus_a.rst_no);
      else n_pass++;
   endtask

   task automatic test_short_release();
      do_release();
      @(posedge clk);
      #1;
      n_total++;
      if (bus_a.state_o !== SYNC || bus_a.rst_no !== 3'b000)
         $display("FAIL short_e1 got rst=%b state=%0d exp rst=000 state=%0d", bus_a.rst_no, bus_a.state_o, SYNC);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk);
         #1;
         n_total++;
         if (bus_a.state_o !== SYNC || bus_a.rst_no !== 3'b000 || bus_a.ready_o !== 1'b0)
            $display("FAIL short_hold%0d got rst=%b ready=%b state=%0d exp rst=000 ready=0 state=%0d",
                     k, bus_a.rst_no, bus_a.ready_o, bus_a.state_o, SYNC);
         else n_pass++;
      end
   endtask

   task automatic test_single_out();
      @(negedge clk);
      rst2_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         @(posedge clk);
         #1;
         n_total++;
         if (bus_b.rst_no !== (e >= 4) || bus_b.ready_o !== (e >= 4))
            $display("FAIL single_e%0d got rst=%b ready=%b exp rst=%b ready=%b",
                     e, bus_b.rst_no, bus_b.ready_o, (e >= 4), (e >= 4));
         else n_pass++;
         n_total++;
         if (bus_b.state_o === STAGE) $display("FAIL single_stage_e%0d got=%0d exp!=%0d", e, bus_b.state_o, STAGE);
         else n_pass++;
         if (e == 4) begin
            n_total++;
            if (bus_b.state_o !== RUN) $display("FAIL single_run got=%0d exp=%0d", bus_b.state_o, RUN);
            else n_pass++;
         end
      end
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_default_sequence();
      test_async_glitch();
      test_soft_in_run();
      test_soft_level();
      test_soft_in_stage();
      test_soft_in_sync();
      test_short_release();
      test_single_out();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
